// File: rtl/timer_start_scheduler.sv
// timer_start_scheduler
//
// Queues tagged start requests for the one-shot countdown timer. Each request
// is issued as a single-cycle start strobe once the timer reports ready. The
// scheduler then follows the timer's busy period and presents a tagged
// completion, which is held until the consumer accepts it. Only one request is
// ever outstanding, so a busy timer never drops a start.
//
// Ports:
//   CLK, nRST        clock; synchronous active-low reset
//   enq__ENA/RDY     request push handshake; RDY is low when the FIFO is full
//   enq_tag          tag stored with the request
//   timerStart__ENA  start strobe to the timer (also pops the FIFO)
//   timerStart__RDY  timer idle (counter == 0)
//   timerBusy        timer busy indication
//   done__ENA/RDY    completion handshake; done_tag is the completed tag
//   pending          FIFO occupancy
//   inFlight         a request has been issued and not yet completed
//   issuedCount      starts issued so far, wraps at 16 bits
module timer_start_scheduler #(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         enq__ENA,
  input  logic [TAG_WIDTH-1:0]         enq_tag,
  output logic                         enq__RDY,
  output logic                         timerStart__ENA,
  input  logic                         timerStart__RDY,
  input  logic                         timerBusy,
  output logic                         done__ENA,
  output logic [TAG_WIDTH-1:0]         done_tag,
  input  logic                         done__RDY,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         inFlight,
  output logic [15:0]                  issuedCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUED  = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state, nextState;
  logic [TAG_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rdPtr, wrPtr;
  logic [CNT_W-1:0]     count;
  logic [TAG_WIDTH-1:0] curTag;
  logic                 push, pop;

  // Full is judged on the registered count only, so a pop in the same cycle
  // does not open a slot until the following cycle.
  assign enq__RDY = (count < CNT_W'(DEPTH));
  assign push     = enq__ENA && enq__RDY;
  assign pop      = timerStart__ENA;
  assign pending  = count;
  assign done_tag = curTag;
  assign inFlight = (state != IDLE);

  // Request storage: data only, no reset needed.
  always_ff @(posedge CLK) begin
    if (push) mem[wrPtr] <= enq_tag;
  end

  // FIFO control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue/completion state machine: state register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      curTag      <= '0;
      issuedCount <= '0;
    end else begin
      state <= nextState;
      if (pop) begin
        curTag      <= mem[rdPtr];
        issuedCount <= issuedCount + 16'd1;
      end
    end
  end

  // Issue/completion state machine: next state and strobes. The strobe is
  // gated by nRST so no start escapes while reset is held.
  always_comb begin
    nextState       = state;
    timerStart__ENA = 1'b0;
    done__ENA       = 1'b0;
    case (state)
      IDLE: begin
        if (nRST && (count != '0) && timerStart__RDY) begin
          timerStart__ENA = 1'b1;
          nextState       = ISSUED;
        end
      end
      // A timer whose busy never rises goes straight to completion.
      ISSUED:  nextState = timerBusy ? RUNNING : DONE;
      RUNNING: if (!timerBusy) nextState = DONE;
      DONE: begin
        done__ENA = 1'b1;
        if (done__RDY) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule
